// File: rtl/bip_dump_ctrl_if.sv
// Signal bundle between the BIP dump controller and its surroundings
// (BIP status, data memory read port, UART transmitter handshake).
interface bip_dump_ctrl_if #(
   parameter int NBITS_D = 16,
   parameter int NBITS_O = 11,
   parameter int NBITS_E = 5,
   parameter int DBIT    = 8
);
   logic               i_halt;
   logic [NBITS_O-1:0] i_pc;
   logic [NBITS_D-1:0] i_acc;
   logic [NBITS_E-1:0] o_mem_addr;
   logic [NBITS_D-1:0] i_mem_data;
   logic               o_tx_start;
   logic [DBIT-1:0]    o_tx_data;
   logic               i_tx_done;
   logic               o_busy;
   logic               o_done;

   // Dump controller side
   modport slave (
      input  i_halt, i_pc, i_acc, i_mem_data, i_tx_done,
      output o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
   );

   // Environment side (BIP core, data memory, UART)
   modport master (
      output i_halt, i_pc, i_acc, i_mem_data, i_tx_done,
      input  o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
   );
endinterface

// File: rtl/bip_dump_ctrl.sv
// On a rising edge of the BIP halt flag, streams PC, ACC and the first CELDAS
// data-memory words to a UART transmitter, low byte first.
module bip_dump_ctrl #(
   parameter int NBITS_D = 16,
   parameter int NBITS_O = 11,
   parameter int NBITS_E = 5,
   parameter int CELDAS  = 10,
   parameter int DBIT    = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   bip_dump_ctrl_if.slave  bus
);

   localparam int NWORDS = CELDAS + 2;
   localparam int KW     = $clog2(NWORDS);
   localparam logic [KW-1:0] LAST_K = KW'(CELDAS + 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SEND_LO,
      WAIT_LO,
      SEND_HI,
      WAIT_HI,
      DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [KW-1:0]      k_reg, k_next;
   logic [NBITS_D-1:0] word_reg, word_next;
   logic               halt_prev_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         word_reg      <= '0;
         halt_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         word_reg      <= word_next;
         halt_prev_reg <= bus.i_halt;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      word_next  = word_reg;
      case (state_reg)
         IDLE: begin
            if (bus.i_halt && !halt_prev_reg) begin
               state_next = FETCH;
               k_next     = '0;
            end
         end
         FETCH: state_next = LATCH;
         LATCH: begin
            // Memory data arrives one cycle after the address issued in FETCH
            if (k_reg == KW'(0))
               word_next = NBITS_D'(bus.i_pc);
            else if (k_reg == KW'(1))
               word_next = bus.i_acc;
            else
               word_next = bus.i_mem_data;
            state_next = SEND_LO;
         end
         SEND_LO: state_next = WAIT_LO;
         WAIT_LO: begin
            if (bus.i_tx_done)
               state_next = SEND_HI;
         end
         SEND_HI: state_next = WAIT_HI;
         WAIT_HI: begin
            if (bus.i_tx_done) begin
               if (k_reg == LAST_K) begin
                  state_next = DONE;
               end else begin
                  k_next     = k_reg + KW'(1);
                  state_next = FETCH;
               end
            end
         end
         DONE: begin
            if (!bus.i_halt)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.o_mem_addr = '0;
      bus.o_tx_start = 1'b0;
      bus.o_tx_data  = '0;
      bus.o_busy     = (state_reg != IDLE) && (state_reg != DONE);
      bus.o_done     = (state_reg == DONE);
      case (state_reg)
         FETCH: begin
            if (k_reg >= KW'(2))
               bus.o_mem_addr = NBITS_E'(k_reg - KW'(2));
         end
         SEND_LO: begin
            bus.o_tx_start = 1'b1;
            bus.o_tx_data  = word_reg[DBIT-1:0];
         end
         WAIT_LO: bus.o_tx_data = word_reg[DBIT-1:0];
         SEND_HI: begin
            bus.o_tx_start = 1'b1;
            bus.o_tx_data  = word_reg[2*DBIT-1:DBIT];
         end
         WAIT_HI: bus.o_tx_data = word_reg[2*DBIT-1:DBIT];
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bip_dump_ctrl.sv
// Directed bench for bip_dump_ctrl: table of dump vectors plus hand-written
// reset, spurious-done and halt-lifecycle sequences.
module tb_bip_dump_ctrl;

   localparam int CELDAS = 10;
   localparam int NBYTES = 2 * (CELDAS + 2);
   localparam int WAIT_LIMIT = 1000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bip_dump_ctrl_if #(.NBITS_D(16), .NBITS_O(11), .NBITS_E(5), .DBIT(8)) ifc ();

   bip_dump_ctrl #(
      .NBITS_D(16), .NBITS_O(11), .NBITS_E(5), .CELDAS(CELDAS), .DBIT(8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifc)
   );

   // Data memory model: mem[i] = 0x0100 + i, registered read
   always @(posedge clk)
      ifc.i_mem_data <= 16'h0100 + {11'b0, ifc.o_mem_addr};

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [10:0] pc;
      logic [15:0] acc;
      int          lo_d;
      int          hi_d;
      bit          spur;
      int          drop_at;
      int          hold;
      logic [7:0]  e0, e1, e2, e3;
   } vec_t;

   vec_t vecs [5];

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < WAIT_LIMIT; n++) begin
         if (ifc.o_tx_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("start_timeout", 32'd0, 32'd1);
   endtask

   // Entered on the negedge of a SEND cycle; answers i_tx_done after d cycles.
   task automatic serve_byte(input logic [7:0] b, input int d, input bit spur,
                             output bit stable);
      stable = 1'b1;
      if (spur) ifc.i_tx_done = 1'b1;
      for (int i = 1; i <= d; i++) begin
         @(negedge clk);
         ifc.i_tx_done = (i == d);
         if (ifc.o_tx_start !== 1'b0 || ifc.o_tx_data !== b) stable = 1'b0;
      end
      @(negedge clk);
      ifc.i_tx_done = 1'b0;
   endtask

   task automatic run_dump(input vec_t v, input int id);
      logic [7:0] exp_b [NBYTES];
      logic [7:0] got;
      bit ok, stable, quiet;
      exp_b[0] = v.e0; exp_b[1] = v.e1; exp_b[2] = v.e2; exp_b[3] = v.e3;
      for (int i = 0; i < CELDAS; i++) begin
         exp_b[4 + 2*i] = 8'(i);
         exp_b[5 + 2*i] = 8'h01;
      end
      ifc.i_pc   = v.pc;
      ifc.i_acc  = v.acc;
      ifc.i_halt = 1'b1;
      for (int b = 0; b < NBYTES; b++) begin
         wait_start(ok);
         if (!ok) return;
         got = ifc.o_tx_data;
         $display("dump %0d byte %0d = %h (expect %h)", id, b, got, exp_b[b]);
         // PC was captured before its first byte went out; later changes are irrelevant
         if (b == 0) ifc.i_pc = ~v.pc;
         if (b == v.drop_at) ifc.i_halt = 1'b0;
         serve_byte(got, (b % 2 == 0) ? v.lo_d : v.hi_d, v.spur && (b % 2 == 0), stable);
         check("byte", {24'd0, got}, {24'd0, exp_b[b]});
         check("byte_stable", {31'd0, stable}, 32'd1);
      end
      check("done_set", {31'd0, ifc.o_done}, 32'd1);
      check("busy_in_done", {31'd0, ifc.o_busy}, 32'd0);
      if (v.hold > 0) begin
         quiet = 1'b1;
         for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (ifc.o_done !== 1'b1 || ifc.o_tx_start !== 1'b0) quiet = 1'b0;
         end
         check("done_hold_halt_high", {31'd0, quiet}, 32'd1);
      end
      ifc.i_halt = 1'b0;
      @(negedge clk);
      check("done_clear", {31'd0, ifc.o_done}, 32'd0);
      check("busy_idle", {31'd0, ifc.o_busy}, 32'd0);
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (ifc.o_tx_start !== 1'b0 || ifc.o_busy !== 1'b0) quiet = 1'b0;
      end
      check("idle_quiet", {31'd0, quiet}, 32'd1);
   endtask

   initial begin
      bit ok, stable, quiet;
      logic [7:0] got;
      vec_t v;

      vecs[0] = '{pc: 11'h005, acc: 16'hA5C3, lo_d: 20,  hi_d: 20, spur: 1'b0, drop_at: -1, hold: 30,
                  e0: 8'h05, e1: 8'h00, e2: 8'hC3, e3: 8'hA5};
      vecs[1] = '{pc: 11'h7FF, acc: 16'h0000, lo_d: 1,   hi_d: 1,  spur: 1'b1, drop_at: -1, hold: 0,
                  e0: 8'hFF, e1: 8'h07, e2: 8'h00, e3: 8'h00};
      vecs[2] = '{pc: 11'h400, acc: 16'hFFFF, lo_d: 500, hi_d: 3,  spur: 1'b0, drop_at: -1, hold: 0,
                  e0: 8'h00, e1: 8'h04, e2: 8'hFF, e3: 8'hFF};
      vecs[3] = '{pc: 11'h123, acc: 16'h8001, lo_d: 2,   hi_d: 5,  spur: 1'b0, drop_at: 3,  hold: 0,
                  e0: 8'h23, e1: 8'h01, e2: 8'h01, e3: 8'h80};
      vecs[4] = '{pc: 11'h2AA, acc: 16'h1234, lo_d: 4,   hi_d: 4,  spur: 1'b0, drop_at: -1, hold: 0,
                  e0: 8'hAA, e1: 8'h02, e2: 8'h34, e3: 8'h12};

      rst = 1'b1;
      ifc.i_halt = 1'b1;
      ifc.i_pc = vecs[0].pc;
      ifc.i_acc = vecs[0].acc;
      ifc.i_tx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, ifc.o_busy}, 32'd0);
      check("rst_done", {31'd0, ifc.o_done}, 32'd0);
      check("rst_start", {31'd0, ifc.o_tx_start}, 32'd0);
      check("rst_data", {24'd0, ifc.o_tx_data}, 32'd0);
      check("rst_addr", {27'd0, ifc.o_mem_addr}, 32'd0);

      // Halt already high at release counts as a rising edge
      rst = 1'b0;
      run_dump(vecs[0], 0);

      // Done pulses while idle must not start anything
      quiet = 1'b1;
      repeat (5) begin
         ifc.i_tx_done = 1'b1;
         @(negedge clk);
         ifc.i_tx_done = 1'b0;
         @(negedge clk);
         if (ifc.o_tx_start !== 1'b0 || ifc.o_busy !== 1'b0) quiet = 1'b0;
      end
      check("idle_spurious_done", {31'd0, quiet}, 32'd1);

      for (int i = 1; i < 5; i++) begin
         run_dump(vecs[i], i);
         repeat (2) @(negedge clk);
      end

      // Reset one cycle after the 7th byte start
      ifc.i_pc = vecs[0].pc;
      ifc.i_acc = vecs[0].acc;
      ifc.i_halt = 1'b1;
      for (int b = 0; b < 6; b++) begin
         wait_start(ok);
         if (!ok) break;
         got = ifc.o_tx_data;
         serve_byte(got, 2, 1'b0, stable);
      end
      wait_start(ok);
      @(negedge clk);
      rst = 1'b1;
      ifc.i_halt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {31'd0, ifc.o_busy}, 32'd0);
      check("midrst_start", {31'd0, ifc.o_tx_start}, 32'd0);
      check("midrst_data", {24'd0, ifc.o_tx_data}, 32'd0);
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (ifc.o_tx_start !== 1'b0 || ifc.o_busy !== 1'b0) quiet = 1'b0;
      end
      check("midrst_quiet", {31'd0, quiet}, 32'd1);
      $display("mid-run reset sequence complete");

      v = vecs[0];
      v.hold = 0;
      run_dump(v, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
